// File: rtl/taillight_seq_if.sv
// rtl/taillight_seq_if.sv - state-code input and lamp outputs of the taillight sequencer
// Optional code_err signal exists only when TAIL_ERR_EN is defined.
interface taillight_seq_if;
    logic [2:0] current_state;
    logic [2:0] left_lamps;
    logic [2:0] right_lamps;
`ifdef TAIL_ERR_EN
    logic       code_err;
`endif

    modport master (
        output current_state,
`ifdef TAIL_ERR_EN
        input  code_err,
`endif
        input  left_lamps,
        input  right_lamps
    );

    modport slave (
        input  current_state,
`ifdef TAIL_ERR_EN
        output code_err,
`endif
        output left_lamps,
        output right_lamps
    );
endinterface

// File: rtl/taillight_seq.sv
// rtl/taillight_seq.sv - decodes the turn/brake state code into animated taillight lamps
// Optional TAIL_ERR_EN: sticky code_err flag and fail-safe hazard flashing for code 111.
module taillight_seq #(
    parameter int TICK_DIV = 4
) (
    input  logic              clock,
    input  logic              reset,
    taillight_seq_if.slave    bus
);
    localparam int            CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(TICK_DIV - 1);

    localparam logic [2:0] C_IDEL   = 3'b000;
    localparam logic [2:0] C_LEFT   = 3'b001;
    localparam logic [2:0] C_RIGHT  = 3'b010;
    localparam logic [2:0] C_LBREAK = 3'b011;
    localparam logic [2:0] C_RBREAK = 3'b100;
    localparam logic [2:0] C_BREAK  = 3'b101;
    localparam logic [2:0] C_HAZARD = 3'b110;
    localparam logic [2:0] C_ILLEGAL = 3'b111;

    logic [2:0]    r_st_q;
    logic [CW-1:0] r_div_cnt;
    logic [1:0]    r_phase;
    logic [2:0]    r_left;
    logic [2:0]    r_right;

    logic [CW-1:0] w_div_nxt;
    logic [1:0]    w_phase_nxt;
    logic [2:0]    w_left_nxt;
    logic [2:0]    w_right_nxt;
    logic [2:0]    w_seq;
    logic [2:0]    w_flash;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_st_q    <= C_IDEL;
            r_div_cnt <= '0;
            r_phase   <= '0;
            r_left    <= '0;
            r_right   <= '0;
        end else begin
            r_st_q    <= bus.current_state;
            r_div_cnt <= w_div_nxt;
            r_phase   <= w_phase_nxt;
            r_left    <= w_left_nxt;
            r_right   <= w_right_nxt;
        end
    end

    // Any code change, even between codes sharing a side, restarts the sweep.
    always_comb begin
        w_div_nxt   = r_div_cnt + 1'b1;
        w_phase_nxt = r_phase;
        if (bus.current_state != r_st_q) begin
            w_div_nxt   = '0;
            w_phase_nxt = '0;
        end else if (r_div_cnt == DIV_LAST) begin
            w_div_nxt   = '0;
            w_phase_nxt = r_phase + 2'd1;
        end
    end

    // Decode uses the phase being loaded so lamps track the new code at its sampling edge.
    always_comb begin
        case (w_phase_nxt)
            2'd0:    w_seq = 3'b000;
            2'd1:    w_seq = 3'b001;
            2'd2:    w_seq = 3'b011;
            default: w_seq = 3'b111;
        endcase
        w_flash     = {3{w_phase_nxt[0]}};
        w_left_nxt  = 3'b000;
        w_right_nxt = 3'b000;
        case (bus.current_state)
            C_LEFT:   w_left_nxt = w_seq;
            C_RIGHT:  w_right_nxt = w_seq;
            C_LBREAK: begin
                w_left_nxt  = w_seq;
                w_right_nxt = 3'b111;
            end
            C_RBREAK: begin
                w_left_nxt  = 3'b111;
                w_right_nxt = w_seq;
            end
            C_BREAK: begin
                w_left_nxt  = 3'b111;
                w_right_nxt = 3'b111;
            end
            C_HAZARD: begin
                w_left_nxt  = w_flash;
                w_right_nxt = w_flash;
            end
`ifdef TAIL_ERR_EN
            C_ILLEGAL: begin
                w_left_nxt  = w_flash;
                w_right_nxt = w_flash;
            end
`endif
            default: ;
        endcase
    end

    assign bus.left_lamps  = r_left;
    assign bus.right_lamps = r_right;

`ifdef TAIL_ERR_EN
    logic r_code_err;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_code_err <= 1'b0;
        end else if (bus.current_state == C_ILLEGAL) begin
            r_code_err <= 1'b1;
        end
    end

    assign bus.code_err = r_code_err;
`endif
endmodule

// File: tb/tb_taillight_seq.sv
// tb/tb_taillight_seq.sv - directed checks of taillight_seq at TICK_DIV 4, 2 and 1
// Checks code_err as well when TAIL_ERR_EN is defined.
module tb_taillight_seq;
    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;

    logic [2:0] seq [4] = '{3'b000, 3'b001, 3'b011, 3'b111};

    taillight_seq_if bus4 ();
    taillight_seq_if bus2 ();
    taillight_seq_if bus1 ();

    taillight_seq #(.TICK_DIV(4)) u_dut4 (.clock(clock), .reset(reset), .bus(bus4.slave));
    taillight_seq #(.TICK_DIV(2)) u_dut2 (.clock(clock), .reset(reset), .bus(bus2.slave));
    taillight_seq #(.TICK_DIV(1)) u_dut1 (.clock(clock), .reset(reset), .bus(bus1.slave));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_code(input logic [2:0] c);
        bus4.current_state = c;
        bus2.current_state = c;
        bus1.current_state = c;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;
        set_code(3'b000);
        repeat (2) step();
        chk("rst_left", bus4.left_lamps, 3'b000);
        chk("rst_right", bus4.right_lamps, 3'b000);
`ifdef TAIL_ERR_EN
        chk("rst_err", {2'b00, bus4.code_err}, 3'b000);
`endif
        set_code(3'b001);
        step();
        chk("rst_hold_left", bus4.left_lamps, 3'b000);

        set_code(3'b000);
        reset = 1'b1;
        step();
        chk("idle_left", bus4.left_lamps, 3'b000);
        chk("idle_right", bus4.right_lamps, 3'b000);

        // LEFT sweep: 4 clocks per phase on dut4, one clock per phase on dut1
        set_code(3'b001);
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("left_L%0d", i), bus4.left_lamps, seq[(i / 4) % 4]);
            chk($sformatf("left_R%0d", i), bus4.right_lamps, 3'b000);
            if (i < 8) chk($sformatf("div1_L%0d", i), bus1.left_lamps, seq[i % 4]);
        end

        set_code(3'b011);
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("lbrk_L%0d", i), bus4.left_lamps, seq[i / 4]);
            chk($sformatf("lbrk_R%0d", i), bus4.right_lamps, 3'b111);
        end

        set_code(3'b101);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("brk_L%0d", i), bus4.left_lamps, 3'b111);
            chk($sformatf("brk_R%0d", i), bus4.right_lamps, 3'b111);
        end

        set_code(3'b010);
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("right_L%0d", i), bus4.left_lamps, 3'b000);
            chk($sformatf("right_R%0d", i), bus4.right_lamps, seq[i / 4]);
        end

        set_code(3'b110);
        for (int i = 0; i < 12; i++) begin
            step();
            chk($sformatf("haz2_L%0d", i), bus2.left_lamps, ((i / 2) % 2 == 1) ? 3'b111 : 3'b000);
            chk($sformatf("haz2_R%0d", i), bus2.right_lamps, ((i / 2) % 2 == 1) ? 3'b111 : 3'b000);
            chk($sformatf("haz4_L%0d", i), bus4.left_lamps, ((i / 4) % 2 == 1) ? 3'b111 : 3'b000);
            chk($sformatf("haz1_R%0d", i), bus1.right_lamps, (i % 2 == 1) ? 3'b111 : 3'b000);
        end

        set_code(3'b100);
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("rbrk_L%0d", i), bus4.left_lamps, 3'b111);
            chk($sformatf("rbrk_R%0d", i), bus4.right_lamps, seq[i / 4]);
        end

        // Asynchronous reset in the middle of a sweep
        set_code(3'b010);
        for (int i = 0; i < 6; i++) step();
        chk("mid_R_before", bus4.right_lamps, 3'b001);
        #2;
        reset = 1'b0;
        #1;
        chk("async_R", bus4.right_lamps, 3'b000);
        chk("async_R1", bus1.right_lamps, 3'b000);
        set_code(3'b000);
        repeat (2) step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("post_rst_L%0d", i), bus4.left_lamps, 3'b000);
            chk($sformatf("post_rst_R%0d", i), bus4.right_lamps, 3'b000);
        end

        // Illegal code 111
        set_code(3'b111);
        for (int i = 0; i < 6; i++) begin
            step();
`ifdef TAIL_ERR_EN
            chk($sformatf("ill_L%0d", i), bus4.left_lamps, ((i / 4) % 2 == 1) ? 3'b111 : 3'b000);
            chk($sformatf("ill_err%0d", i), {2'b00, bus4.code_err}, 3'b001);
`else
            chk($sformatf("ill_L%0d", i), bus4.left_lamps, 3'b000);
            chk($sformatf("ill_R%0d", i), bus1.right_lamps, 3'b000);
`endif
        end
        set_code(3'b000);
        step();
        chk("ill_idle_L", bus4.left_lamps, 3'b000);
        chk("ill_idle_R", bus4.right_lamps, 3'b000);
`ifdef TAIL_ERR_EN
        chk("err_sticky", {2'b00, bus4.code_err}, 3'b001);
        reset = 1'b0;
        #1;
        chk("err_cleared", {2'b00, bus4.code_err}, 3'b000);
        reset = 1'b1;
`endif
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
